cartridge_chr_mapper: RTL and testbench
=======================================

Name: cartridge_chr_mapper

Overview:
- Parametrised successor to the fixed 8 KB CHR cartridge: banked CHR memory with a serial-load mapper register file and runtime-selectable nametable mirroring.
- Sits on the cartridge side of the PPU bus, driving CIRAM control, plus a CPU-side serial register port for bank and mode writes.
- PPU strobes are asynchronous to MasterClk and are synchronised internally.
- CHR storage is an internal array of 4 KB banks, RAM or ROM by parameter.

Parameters:
- CHR_BANK_BITS, 3, log2 of the number of 4 KB CHR banks (3 gives 32 KB); minimum 1.
- CHR_WRITABLE, 1, 1 = CHR-RAM (PPU writes allowed); 0 = CHR-ROM (PPU writes ignored).
- CTRL_RESET, 5'b00010, reset value of the control register.

Ports:
- MasterClk  input  1  system clock, all logic on the rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- PPU_A  input  14  PPU address bus.
- PPU_D_IN  input  8  PPU write data.
- PPU_D_OUT  output  8  PPU read data (registered).
- PPU_D_OE  output  1  high = cartridge drives the PPU data bus.
- PPU_RD_N  input  1  PPU read strobe, active low, asynchronous.
- PPU_WR_N  input  1  PPU write strobe, active low, asynchronous.
- CIRAM_A10  output  1  console VRAM A10 select (mirroring).
- CIRAM_CE_N  output  1  console VRAM chip enable, active low.
- CPU_WR_STB  input  1  one-cycle pulse, synchronous, marks a mapper register write.
- CPU_A  input  2  CPU address bits [14:13], selecting the target register.
- CPU_D  input  2  {D7, D0} of the CPU write data.

Behaviour:
- Reset (async assert, sync release), values: control=CTRL_RESET, chr0=0, chr1=0, shift=0, count=0, synchroniser flops=1, PPU_D_OUT=0, PPU_D_OE=0. CHR array contents are not reset.
- Serial loader (on CPU_WR_STB):
  - If D7=1: shift=0 and count=0. No register changes.
  - Else: shift={D0, shift[4:1]} (LSB first) and count+1.
  - On the 5th accepted bit, the assembled 5-bit value commits that same cycle to the register selected by CPU_A: 00 control, 01 chr0, 10 chr1, 11 discarded. shift and count then clear.
  - CPU_WR_STB with D7=1 on what would be the 5th bit: the reset wins and nothing commits.
- control fields: [1:0] mirroring, [4] CHR mode (0 = 8 KB, 1 = two 4 KB); bits [3:2] are stored and unused.
- Bank map: bank is CHR_BANK_BITS wide, taken from the low bits of chr0/chr1. Bank bits above CHR_BANK_BITS are ignored, so values wrap.
  - 8 KB mode: bank={chr0[CHR_BANK_BITS-1:1], PPU_A[12]}.
  - 4 KB mode: bank = PPU_A[12] ? chr1 : chr0.
  - Physical address={bank, PPU_A[11:0]}.
- Mirroring (combinational, from current control):
  - 00: CIRAM_A10=0 (one-screen low).
  - 01: CIRAM_A10=1 (one-screen high).
  - 10: CIRAM_A10=PPU_A[10] (vertical).
  - 11: CIRAM_A10=PPU_A[11] (horizontal).
- CIRAM_CE_N = ~PPU_A[13], combinational.
- Strobe synchroniser: PPU_RD_N and PPU_WR_N each pass through 2 flops, then a 3rd flop for edge detect. A falling edge is flagged in cycle E, 3 rising edges after the input falls.
- Read:
  - In cycle E, with RD falling, PPU_A[13]=0 and WR_N(sync)=1: the physical address is captured and the array read issued.
  - PPU_D_OUT updates at E+1 and holds until the next read.
  - Total latency is 4 MasterClk edges from the RD_N fall.
  - PPU_D_OE=1 from E+1 while synced RD_N=0 and PPU_A[13]=0; it drops on the first cycle either condition fails.
- Write:
  - In cycle E, with WR falling, PPU_A[13]=0, CHR_WRITABLE=1 and RD_N(sync)=1: PPU_D_IN is written to the physical address.
  - PPU_D_OE stays 0 during writes.
- Boundary cases:
  - Both synced strobes low in cycle E: no read, no write, OE=0.
  - A13=1 accesses are never served.
  - A bank register write committing in the same cycle as a PPU access: the access uses the old mapping and the new mapping applies from the next cycle.
  - Reset asserted mid-access: OE drops immediately and no write completes.

Test Plan:
- Reset, then read 0x0005 with preloaded bank0[5]=0xA5 -> PPU_D_OUT=0xA5 on the 4th edge after RD_N falls; OE high until RD_N rises; CIRAM_A10 follows PPU_A[10] (vertical).
- Serial write 5'b10010 to control, then 5'b00011 to chr0 and 5'b00110 to chr1 (CHR_BANK_BITS=3) -> reads at 0x0000 hit bank 3, reads at 0x1000 hit bank 6.
- Four bits shifted, then D7=1, then five bits 5'b00011 to control -> control=0x03, horizontal mirroring: PPU_A=0x2800 gives CIRAM_A10=1, PPU_A=0x2400 gives CIRAM_A10=0.
- CHR_WRITABLE=1: write 0x3C to 0x1FFF, read back -> 0x3C. CHR_WRITABLE=0: same write followed by read -> original contents unchanged.
- PPU_A=0x2000 with RD_N low -> OE stays 0, CIRAM_CE_N=0. Both strobes falling together -> no memory change, OE=0.
- Assert Reset_n during an active read -> OE=0 at once; after release, control=CTRL_RESET and the loader count is 0 (a fresh 5-bit sequence commits correctly).

Source files
------------

// File: rtl/cartridge_chr_mapper_if.sv
// PPU bus, CIRAM control and CPU serial register port of the CHR mapper.
interface cartridge_chr_mapper_if;
    logic [13:0] PPU_A;
    logic [7:0]  PPU_D_IN;
    logic [7:0]  PPU_D_OUT;
    logic        PPU_D_OE;
    logic        PPU_RD_N;
    logic        PPU_WR_N;
    logic        CIRAM_A10;
    logic        CIRAM_CE_N;
    logic        CPU_WR_STB;
    logic [1:0]  CPU_A;
    logic [1:0]  CPU_D;

    // Console / CPU side: drives strobes, addresses and write data.
    modport master (
        output PPU_A, PPU_D_IN, PPU_RD_N, PPU_WR_N, CPU_WR_STB, CPU_A, CPU_D,
        input  PPU_D_OUT, PPU_D_OE, CIRAM_A10, CIRAM_CE_N
    );

    // Cartridge side: the mapper itself.
    modport slave (
        input  PPU_A, PPU_D_IN, PPU_RD_N, PPU_WR_N, CPU_WR_STB, CPU_A, CPU_D,
        output PPU_D_OUT, PPU_D_OE, CIRAM_A10, CIRAM_CE_N
    );
endinterface

// File: rtl/cartridge_chr_mapper.sv
// Banked CHR memory with a serial-load mapper register file and selectable
// nametable mirroring. PPU strobes are asynchronous and resynchronised here.
module cartridge_chr_mapper #(
    parameter int unsigned CHR_BANK_BITS = 3,
    parameter bit          CHR_WRITABLE  = 1'b1,
    parameter logic [4:0]  CTRL_RESET    = 5'b00010
) (
    input logic                   MasterClk,
    input logic                   Reset_n,
    cartridge_chr_mapper_if.slave bus
);

    localparam int unsigned ADDR_W = CHR_BANK_BITS + 12;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic [1:0]               rst_sync_q;
    logic                     rst_int_n;

    logic [4:0]               ctrl_q, ctrl_d;
    logic [4:0]               chr0_q, chr0_d;
    logic [4:0]               chr1_q, chr1_d;
    logic [4:0]               shift_q, shift_d;
    logic [2:0]               count_q, count_d;
    logic [4:0]               load_val;

    logic [2:0]               rd_sync_q;
    logic [2:0]               wr_sync_q;
    logic                     rd_fall, wr_fall;
    logic                     rd_go, wr_go;

    logic [CHR_BANK_BITS-1:0] bank_sel;
    logic [ADDR_W-1:0]        phys_addr;
    logic [ADDR_W-1:0]        rd_addr_q;
    logic                     rd_issue_q;
    logic [7:0]               dout_q;
    logic                     oe_q, oe_d;
    logic                     a10_c;

    logic [7:0]               chr_mem [DEPTH];

    logic                     unused_bits;

    // Reset: asserts asynchronously, releases on a clock edge.
    always_ff @(posedge MasterClk or negedge Reset_n) begin
        if (!Reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // Serial loader: LSB-first shift, commit on the fifth accepted bit.
    assign load_val = {bus.CPU_D[0], shift_q[4:1]};
    always_comb begin
        ctrl_d  = ctrl_q;
        chr0_d  = chr0_q;
        chr1_d  = chr1_q;
        shift_d = shift_q;
        count_d = count_q;
        if (bus.CPU_WR_STB) begin
            if (bus.CPU_D[1]) begin
                shift_d = '0;
                count_d = '0;
            end else if (count_q == 3'd4) begin
                case (bus.CPU_A)
                    2'b00:   ctrl_d = load_val;
                    2'b01:   chr0_d = load_val;
                    2'b10:   chr1_d = load_val;
                    default: ;
                endcase
                shift_d = '0;
                count_d = '0;
            end else begin
                shift_d = load_val;
                count_d = count_q + 3'd1;
            end
        end
    end

    // Mapper register file.
    always_ff @(posedge MasterClk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ctrl_q  <= CTRL_RESET;
            chr0_q  <= '0;
            chr1_q  <= '0;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            chr0_q  <= chr0_d;
            chr1_q  <= chr1_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Strobe synchronisers: two flops to resync, a third for edge detect.
    always_ff @(posedge MasterClk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rd_sync_q <= '1;
            wr_sync_q <= '1;
        end else begin
            rd_sync_q <= {rd_sync_q[1:0], bus.PPU_RD_N};
            wr_sync_q <= {wr_sync_q[1:0], bus.PPU_WR_N};
        end
    end

    assign rd_fall = ~rd_sync_q[1] & rd_sync_q[2];
    assign wr_fall = ~wr_sync_q[1] & wr_sync_q[2];
    // A simultaneous fall on both strobes serves neither.
    assign rd_go   = rd_fall & ~bus.PPU_A[13] & wr_sync_q[1];
    assign wr_go   = wr_fall & ~bus.PPU_A[13] & rd_sync_q[1] & CHR_WRITABLE;

    // Bank map: 8 KB mode pairs banks with PPU_A[12] as the low bit.
    always_comb begin
        bank_sel = CHR_BANK_BITS'(chr0_q);
        if (ctrl_q[4]) begin
            if (bus.PPU_A[12]) bank_sel = CHR_BANK_BITS'(chr1_q);
        end else begin
            bank_sel[0] = bus.PPU_A[12];
        end
    end
    assign phys_addr = {bank_sel, bus.PPU_A[11:0]};

    // Output enable holds while the synced read stays low inside CHR space.
    always_comb begin
        oe_d = (rd_issue_q | oe_q) & ~rd_sync_q[1] & ~bus.PPU_A[13];
    end

    // Read path: capture address in the detect cycle, present data next cycle.
    always_ff @(posedge MasterClk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rd_issue_q <= 1'b0;
            rd_addr_q  <= '0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
        end else begin
            rd_issue_q <= rd_go;
            if (rd_go)      rd_addr_q <= phys_addr;
            if (rd_issue_q) dout_q    <= chr_mem[rd_addr_q];
            oe_q <= oe_d;
        end
    end

    // CHR-RAM write port; CHR-ROM builds have no writer.
    if (CHR_WRITABLE) begin : g_chr_ram
        always_ff @(posedge MasterClk) begin
            if (wr_go) chr_mem[phys_addr] <= bus.PPU_D_IN;
        end
    end

    // Nametable mirroring from the current control register.
    always_comb begin
        case (ctrl_q[1:0])
            2'b00:   a10_c = 1'b0;
            2'b01:   a10_c = 1'b1;
            2'b10:   a10_c = bus.PPU_A[10];
            default: a10_c = bus.PPU_A[11];
        endcase
    end

    assign bus.PPU_D_OUT  = dout_q;
    assign bus.PPU_D_OE   = oe_q;
    assign bus.CIRAM_A10  = a10_c;
    assign bus.CIRAM_CE_N = ~bus.PPU_A[13];

    // Control bits [3:2] are stored but have no function; ROM builds ignore write data.
    assign unused_bits = ^{ctrl_q[3:2], bus.PPU_D_IN, wr_go};

endmodule

// File: tb/tb_cartridge_chr_mapper.sv
// Scoreboard bench: a CHR-RAM and a CHR-ROM mapper driven with identical stimulus.
module tb_cartridge_chr_mapper;

    localparam int unsigned BB     = 3;
    localparam int          NB     = 8;
    localparam int          PHYS_N = NB * 4096;

    logic clk;
    logic rst_n;

    cartridge_chr_mapper_if ifw();
    cartridge_chr_mapper_if ifr();

    assign ifr.PPU_A      = ifw.PPU_A;
    assign ifr.PPU_D_IN   = ifw.PPU_D_IN;
    assign ifr.PPU_RD_N   = ifw.PPU_RD_N;
    assign ifr.PPU_WR_N   = ifw.PPU_WR_N;
    assign ifr.CPU_WR_STB = ifw.CPU_WR_STB;
    assign ifr.CPU_A      = ifw.CPU_A;
    assign ifr.CPU_D      = ifw.CPU_D;

    cartridge_chr_mapper #(.CHR_BANK_BITS(BB), .CHR_WRITABLE(1'b1), .CTRL_RESET(5'b00010))
        dut_ram (.MasterClk(clk), .Reset_n(rst_n), .bus(ifw));
    cartridge_chr_mapper #(.CHR_BANK_BITS(BB), .CHR_WRITABLE(1'b0), .CTRL_RESET(5'b00010))
        dut_rom (.MasterClk(clk), .Reset_n(rst_n), .bus(ifr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors;
    int checks;

    // Reference model state.
    logic [7:0] ram_m [int];
    logic [7:0] rom_m [PHYS_N];
    int         m_ctrl, m_chr0, m_chr1;
    int         sq [$];

    logic [7:0] exp_ram [$];
    logic [7:0] exp_rom [$];
    logic       prev_oe_w, prev_oe_r;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input int act_w, input int act_r, input int exp);
        chk({name, "_ram"}, act_w, exp);
        chk({name, "_rom"}, act_r, exp);
    endtask

    function automatic int phys(input int a);
        int bank;
        if (((m_ctrl >> 4) & 1) == 1)
            bank = ((((a >> 12) & 1) == 1) ? m_chr1 : m_chr0) % NB;
        else
            bank = ((m_chr0 % NB) / 2) * 2 + ((a >> 12) & 1);
        return bank * 4096 + (a % 4096);
    endfunction

    function automatic int exp_a10(input int a);
        case (m_ctrl & 3)
            0:       return 0;
            1:       return 1;
            2:       return (a >> 10) & 1;
            default: return (a >> 11) & 1;
        endcase
    endfunction

    function automatic void model_reset();
        m_ctrl = 2;
        m_chr0 = 0;
        m_chr1 = 0;
        sq.delete();
    endfunction

    function automatic void model_cpu(input int a, input int d7, input int d0);
        int v;
        if (d7 != 0) begin
            sq.delete();
        end else begin
            sq.push_back(d0 & 1);
            if (sq.size() == 5) begin
                v = 0;
                for (int i = 0; i < 5; i++) v += sq[i] << i;
                case (a)
                    0:       m_ctrl = v;
                    1:       m_chr0 = v;
                    2:       m_chr1 = v;
                    default: ;
                endcase
                sq.delete();
            end
        end
    endfunction

    // Monitor: each rising OE presents one read result.
    always @(negedge clk) begin
        logic [7:0] e;
        if (ifw.PPU_D_OE && !prev_oe_w) begin
            if (exp_ram.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_ram_unexpected actual=%0h required=no_read", ifw.PPU_D_OUT);
            end else begin
                e = exp_ram.pop_front();
                chk("rd_ram", int'(ifw.PPU_D_OUT), int'(e));
            end
        end
        if (ifr.PPU_D_OE && !prev_oe_r) begin
            if (exp_rom.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_rom_unexpected actual=%0h required=no_read", ifr.PPU_D_OUT);
            end else begin
                e = exp_rom.pop_front();
                chk("rd_rom", int'(ifr.PPU_D_OUT), int'(e));
            end
        end
        prev_oe_w <= ifw.PPU_D_OE;
        prev_oe_r <= ifr.PPU_D_OE;
    end

    task automatic cpu(input int a, input int d7, input int d0);
        @(posedge clk); #1;
        ifw.CPU_WR_STB = 1'b1;
        ifw.CPU_A      = 2'(a);
        ifw.CPU_D      = {1'(d7), 1'(d0)};
        model_cpu(a, d7, d0);
        @(posedge clk); #1;
        ifw.CPU_WR_STB = 1'b0;
    endtask

    task automatic serial(input int a, input int v);
        for (int i = 0; i < 5; i++) cpu(a, 0, (v >> i) & 1);
    endtask

    task automatic chk_mirror(input int a);
        @(posedge clk); #1;
        ifw.PPU_A = 14'(a);
        #1;
        chk2("ciram_a10", int'(ifw.CIRAM_A10), int'(ifr.CIRAM_A10), exp_a10(a));
        chk2("ciram_ce_n", int'(ifw.CIRAM_CE_N), int'(ifr.CIRAM_CE_N), ((a >> 13) & 1) ^ 1);
    endtask

    task automatic push_read(input int a);
        int p;
        p = phys(a);
        exp_ram.push_back(ram_m.exists(p) ? ram_m[p] : 8'h00);
        exp_rom.push_back(rom_m[p]);
    endtask

    task automatic rd(input int a);
        int serve;
        serve = (a < 'h2000) ? 1 : 0;
        @(posedge clk); #1;
        ifw.PPU_A    = 14'(a);
        ifw.PPU_RD_N = 1'b0;
        if (serve != 0) push_read(a);
        repeat (3) @(posedge clk);
        #1;
        chk2("oe_early", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 0);
        chk("ce_n_rd", int'(ifw.CIRAM_CE_N), serve);
        @(posedge clk); #1;
        chk2("oe_on", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), serve);
        repeat (2) @(posedge clk);
        #1;
        ifw.PPU_RD_N = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk2("oe_off", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 0);
    endtask

    task automatic wr(input int a, input int d);
        @(posedge clk); #1;
        ifw.PPU_A    = 14'(a);
        ifw.PPU_D_IN = 8'(d);
        ifw.PPU_WR_N = 1'b0;
        if (a < 'h2000) ram_m[phys(a)] = 8'(d);
        repeat (5) @(posedge clk);
        #1;
        chk2("oe_wr", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 0);
        ifw.PPU_WR_N = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic both(input int a, input int d);
        @(posedge clk); #1;
        ifw.PPU_A    = 14'(a);
        ifw.PPU_D_IN = 8'(d);
        ifw.PPU_RD_N = 1'b0;
        ifw.PPU_WR_N = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk2("oe_both", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 0);
        ifw.PPU_RD_N = 1'b1;
        ifw.PPU_WR_N = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int addrs [$];
        int a;
        errors = 0;
        checks = 0;
        prev_oe_w = 1'b0;
        prev_oe_r = 1'b0;
        rst_n = 1'b0;
        ifw.PPU_A = '0; ifw.PPU_D_IN = '0; ifw.PPU_RD_N = 1'b1; ifw.PPU_WR_N = 1'b1;
        ifw.CPU_WR_STB = 1'b0; ifw.CPU_A = '0; ifw.CPU_D = '0;
        model_reset();
        for (int i = 0; i < PHYS_N; i++) begin
            rom_m[i] = 8'($urandom);
            dut_rom.chr_mem[15'(i)] = rom_m[i];
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk2("rst_oe", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 0);
        chk2("rst_dout", int'(ifw.PPU_D_OUT), int'(ifr.PPU_D_OUT), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk_mirror('h2400);
        chk_mirror('h2800);

        // Basic write then read in bank 0.
        wr('h0005, 'hA5);
        rd('h0005);

        // 4 KB mode, chr0=3, chr1=6.
        serial(0, 5'b10010);
        serial(1, 5'b00011);
        serial(2, 5'b00110);
        wr('h0000, 'h31);
        wr('h1000, 'h62);
        rd('h0000);
        rd('h1000);
        chk_mirror('h2400);

        // Aborted sequence, then horizontal mirroring in 8 KB mode.
        for (int i = 0; i < 4; i++) cpu(0, 0, 1);
        cpu(0, 1, 0);
        serial(0, 5'b00011);
        chk_mirror('h2800);
        chk_mirror('h2400);

        // Top-of-window write/read; ROM copy must be unchanged.
        wr('h1FFF, 'h3C);
        rd('h1FFF);

        // A13 space never served; simultaneous strobes do nothing.
        rd('h2000);
        both('h1FFF, 'h99);
        rd('h1FFF);

        // Bank commit in the read's detect cycle: read uses the old mapping.
        wr('h0010, 'h11);
        cpu(1, 0, 1); cpu(1, 0, 0); cpu(1, 0, 1); cpu(1, 0, 0);
        @(posedge clk); #1;
        ifw.PPU_A    = 14'h0010;
        ifw.PPU_RD_N = 1'b0;
        push_read('h0010);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifw.CPU_WR_STB = 1'b1; ifw.CPU_A = 2'b01; ifw.CPU_D = 2'b00;
        model_cpu(1, 0, 0);
        @(posedge clk); #1;
        ifw.CPU_WR_STB = 1'b0;
        @(posedge clk); #1;
        chk2("oe_commit", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 1);
        repeat (2) @(posedge clk);
        #1;
        ifw.PPU_RD_N = 1'b1;
        repeat (4) @(posedge clk);
        wr('h0010, 'h55);
        rd('h0010);

        // Randomised phases: program mapper, write, read back.
        for (int p = 0; p < 6; p++) begin
            repeat ($urandom_range(2, 8)) cpu($urandom_range(0, 3), ($urandom_range(0, 9) == 0) ? 1 : 0, $urandom_range(0, 1));
            cpu(0, 1, 0);
            serial($urandom_range(0, 3), $urandom_range(0, 31));
            serial($urandom_range(0, 2), $urandom_range(0, 31));
            addrs.delete();
            for (int k = 0; k < 4; k++) begin
                a = $urandom_range(0, 'h1FFF);
                if ($urandom_range(0, 3) == 0) a = a | 'h2000;
                wr(a, $urandom_range(0, 255));
                addrs.push_back(a);
            end
            for (int k = 3; k >= 0; k--) rd(addrs[k]);
            chk_mirror($urandom_range(0, 'h3FFF));
        end

        // Reset during an active read: OE drops at once.
        wr('h0123, 'h77);
        @(posedge clk); #1;
        ifw.PPU_A    = 14'h0123;
        ifw.PPU_RD_N = 1'b0;
        push_read('h0123);
        repeat (5) @(posedge clk);
        #1;
        chk2("oe_pre_rst", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 1);
        rst_n = 1'b0;
        #1;
        chk2("oe_rst", int'(ifw.PPU_D_OE), int'(ifr.PPU_D_OE), 0);
        model_reset();
        ifw.PPU_RD_N = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk2("dout_rst", int'(ifw.PPU_D_OUT), int'(ifr.PPU_D_OUT), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        chk_mirror('h2400);

        // Reset during a write: the write must not land; loader count clears.
        wr('h0200, 'h42);
        cpu(0, 0, 1); cpu(0, 0, 1); cpu(0, 0, 1);
        @(posedge clk); #1;
        ifw.PPU_A    = 14'h0200;
        ifw.PPU_D_IN = 8'hBD;
        ifw.PPU_WR_N = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        ifw.PPU_WR_N = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        rd('h0200);
        serial(0, 5'b00011);
        chk_mirror('h2800);
        chk_mirror('h2400);

        repeat (10) @(posedge clk);
        #1;
        chk("sb_ram_empty", exp_ram.size(), 0);
        chk("sb_rom_empty", exp_rom.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
